// File: rtl/score_keeper.sv
// Two-digit BCD score keeper with lives, difficulty level and speed output.
// Raw buttons are synchronized and debounced into single-cycle press events.

module score_keeper_debounce #(
    parameter int CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [1:0]    sync;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level;
    // the level flips on the CYCLES-th such sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync     <= 2'b00;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            sync     <= {sync[0], raw};
            stable_q <= stable;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pulse = stable & ~stable_q;
endmodule

module score_keeper #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BASE_SPEED      = 25000000,
    parameter int SPEED_STEP      = 2500000,
    parameter int MIN_SPEED       = 5000000,
    parameter int START_LIVES     = 3
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               hit,
    input  logic               miss,
    output logic [3:0]         score,
    output logic [3:0]         tens_score,
    output logic signed [31:0] speed_control,
    output logic [2:0]         level,
    output logic [2:0]         lives,
    output logic               game_over,
    output logic [1:0]         fsm_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t state;

    logic start_p;
    logic hit_p;
    logic miss_p;

    score_keeper_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (start),
        .pulse (start_p)
    );

    score_keeper_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_hit (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (hit),
        .pulse (hit_p)
    );

    score_keeper_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_miss (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (miss),
        .pulse (miss_p)
    );

    logic score_at_max;
    logic last_life;
    logic end_by_hit;
    logic end_by_miss;

    always_comb begin
        score_at_max = (tens_score == 4'd9) && (score == 4'd9);
        last_life    = (lives == 3'd1);
        end_by_hit   = hit_p && score_at_max;
        end_by_miss  = miss_p && last_life;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            score      <= 4'd0;
            tens_score <= 4'd0;
            lives      <= 3'd0;
            game_over  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_p) begin
                        state      <= PLAY;
                        score      <= 4'd0;
                        tens_score <= 4'd0;
                        lives      <= 3'(START_LIVES);
                    end
                end
                PLAY: begin
                    if (hit_p && !score_at_max) begin
                        if (score == 4'd9) begin
                            score      <= 4'd0;
                            tens_score <= tens_score + 4'd1;
                        end else begin
                            score <= score + 4'd1;
                        end
                    end
                    if (miss_p && lives != 3'd0) begin
                        lives <= lives - 3'd1;
                    end
                    // game_over rises with the state change so it is high exactly while in OVER
                    if (end_by_hit || end_by_miss) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end
                end
                OVER: begin
                    if (start_p) begin
                        state     <= IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

    longint speed_calc;
    logic signed [31:0] speed_next;

    // Wide arithmetic so a large level*SPEED_STEP cannot wrap past the floor.
    always_comb begin
        speed_calc = longint'(BASE_SPEED) - longint'(level) * longint'(SPEED_STEP);
        if (speed_calc < longint'(MIN_SPEED)) begin
            speed_next = MIN_SPEED;
        end else begin
            speed_next = speed_calc[31:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            level         <= 3'd0;
            speed_control <= BASE_SPEED;
        end else begin
            level         <= (tens_score > 4'd7) ? 3'd7 : tens_score[2:0];
            speed_control <= speed_next;
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// Randomized plus directed bench for score_keeper against a game-rule model.
// A driver pushes expected snapshots; a negedge monitor pops and compares.

module tb_score_keeper;
    localparam int DEB   = 4;
    localparam int BASE  = 25000000;
    localparam int STEP  = 2500000;
    localparam int MINS  = 5000000;
    localparam int SL    = 3;
    localparam int GAP   = 14;

    logic               CLK = 1'b0;
    logic               RST_N = 1'b0;
    logic               start = 1'b0;
    logic               hit = 1'b0;
    logic               miss = 1'b0;
    logic [3:0]         score;
    logic [3:0]         tens_score;
    logic signed [31:0] speed_control;
    logic [2:0]         level;
    logic [2:0]         lives;
    logic               game_over;
    logic [1:0]         fsm_state;

    always #5 CLK = ~CLK;

    score_keeper #(
        .DEBOUNCE_CYCLES (DEB),
        .BASE_SPEED      (BASE),
        .SPEED_STEP      (STEP),
        .MIN_SPEED       (MINS),
        .START_LIVES     (SL)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .start         (start),
        .hit           (hit),
        .miss          (miss),
        .score         (score),
        .tens_score    (tens_score),
        .speed_control (speed_control),
        .level         (level),
        .lives         (lives),
        .game_over     (game_over),
        .fsm_state     (fsm_state)
    );

    // Model: 0 = idle, 1 = playing, 2 = game over; score as a plain integer 0..99.
    int m_state = 0;
    int m_score = 0;
    int m_lives = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [46:0] exp_q[$];
    string       name_q[$];

    function automatic logic [46:0] pack_exp();
        int lv;
        int sp;
        lv = m_score / 10;
        if (lv > 7) lv = 7;
        sp = BASE - lv * STEP;
        if (sp < MINS) sp = MINS;
        return {4'(m_score % 10), 4'(m_score / 10), 3'(lv), 3'(m_lives),
                (m_state == 2), 32'(sp)};
    endfunction

    task automatic push(input string nm);
        exp_q.push_back(pack_exp());
        name_q.push_back(nm);
    endtask

    task automatic model_event(input bit s, input bit h, input bit m);
        bit ends;
        ends = 1'b0;
        case (m_state)
            0: if (s) begin
                m_state = 1;
                m_score = 0;
                m_lives = SL;
            end
            1: begin
                if (h) begin
                    if (m_score == 99) ends = 1'b1;
                    else m_score = m_score + 1;
                end
                if (m) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) ends = 1'b1;
                end
                if (ends) m_state = 2;
            end
            default: if (s) m_state = 0;
        endcase
    endtask

    task automatic press(input bit s, input bit h, input bit m, input int hold, input string nm);
        @(posedge CLK); #1;
        start = s; hit = h; miss = m;
        repeat (hold) @(posedge CLK);
        #1;
        start = 1'b0; hit = 1'b0; miss = 1'b0;
        repeat (GAP) @(posedge CLK);
        #1;
        model_event(s, h, m);
        push(nm);
    endtask

    task automatic glitch(input bit s, input bit h, input bit m, input int hold, input string nm);
        @(posedge CLK); #1;
        start = s; hit = h; miss = m;
        repeat (hold) @(posedge CLK);
        #1;
        start = 1'b0; hit = 1'b0; miss = 1'b0;
        repeat (GAP) @(posedge CLK);
        #1;
        push(nm);
    endtask

    task automatic do_reset(input string nm);
        @(posedge CLK); #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        m_state = 0;
        m_score = 0;
        m_lives = 0;
        push(nm);
    endtask

    initial begin : monitor
        logic [46:0] e;
        logic [46:0] a;
        string nm;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {score, tens_score, level, lives, game_over, speed_control};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got score=%0d tens=%0d level=%0d lives=%0d go=%0d speed=%0d, want score=%0d tens=%0d level=%0d lives=%0d go=%0d speed=%0d",
                             nm, a[46:43], a[42:39], a[38:36], a[35:33], a[32], a[31:0],
                             e[46:43], e[42:39], e[38:36], e[35:33], e[32], e[31:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "time limit");
    end

    initial begin : driver
        int r;
        repeat (3) @(posedge CLK);
        do_reset("reset_values");

        press(0, 1, 0, 8, "hit_in_idle");
        press(0, 0, 1, 8, "miss_in_idle");
        press(1, 0, 0, 8, "start_to_play");
        glitch(0, 1, 0, 3, "hit_glitch_3");
        press(0, 1, 0, 20, "hit_held_20");
        for (int i = 2; i <= 98; i++) press(0, 1, 0, $urandom_range(5, 12), "hit_count");
        press(1, 0, 0, 8, "start_in_play");
        press(0, 1, 0, 8, "hit_to_99");
        press(0, 1, 0, 8, "hit_at_99");
        press(0, 1, 0, 8, "hit_in_over");
        press(0, 0, 1, 8, "miss_in_over");
        press(1, 0, 0, 8, "start_over_to_idle");
        press(1, 0, 0, 8, "start_idle_to_play");

        for (int i = 0; i < 3; i++) press(0, 0, 1, 8, "miss_lives");
        press(1, 0, 0, 8, "start_over_to_idle");
        press(1, 0, 0, 8, "start_idle_to_play");
        press(0, 0, 1, 8, "miss_lives");
        press(0, 0, 1, 8, "miss_lives");
        press(0, 1, 1, 8, "hit_miss_last_life");
        press(1, 0, 0, 8, "start_over_to_idle");
        press(1, 0, 0, 8, "start_idle_to_play");

        for (int i = 0; i < 45; i++) press(0, 1, 0, 6, "hit_to_45");
        @(posedge CLK); #1;
        hit = 1'b1;
        repeat (3) @(posedge CLK);
        do_reset("reset_mid_play");
        repeat (10) @(posedge CLK);
        #1;
        hit = 1'b0;
        repeat (GAP) @(posedge CLK);
        #1;
        push("hit_after_reset");

        @(posedge CLK); #1;
        start = 1'b1;
        repeat (2) @(posedge CLK);
        do_reset("reset_start_held");
        repeat (10) @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (GAP) @(posedge CLK);
        #1;
        model_event(1, 0, 0);
        push("start_held_through_reset");

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 15);
            if (r <= 6)       press(0, 1, 0, $urandom_range(5, 12), "rand_hit");
            else if (r <= 8)  press(0, 0, 1, $urandom_range(5, 12), "rand_miss");
            else if (r == 9)  press(0, 1, 1, $urandom_range(5, 12), "rand_hit_miss");
            else if (r <= 11) press(1, 0, 0, $urandom_range(5, 12), "rand_start");
            else if (r == 12) glitch(0, 1, 0, $urandom_range(1, 3), "rand_hit_glitch");
            else if (r == 13) glitch(1, 0, 1, $urandom_range(1, 3), "rand_start_miss_glitch");
            else if (r == 14) do_reset("rand_reset");
            else              press(0, 1, 0, 20, "rand_hit_long");
        end

        repeat (4) @(posedge CLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
